fnd_display_sequencer: RTL and testbench

- Upstream stage of the 6-digit FND segment driver.
- Accepts calculator result events over a valid/ready handshake and decides which 32-bit display code to present on fnd_serial.
- Display codes are either a signed number or one of the reserved word codes.
- Sequences: HAPPY banner after reset, operator word for a fixed hold time, then result or a blinking error word.

---
 rtl/fnd_display_sequencer_if.sv | 12 +
 rtl/fnd_display_sequencer.sv | 165 ++++++++++++++++
 tb/tb_fnd_display_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fnd_display_sequencer_if.sv
// Request channel into the FND display sequencer: valid/ready handshake carrying
// one calculator result (operator, signed value, upstream error flag).
interface fnd_display_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_value;
  logic        req_err;

  modport master (output req_valid, req_op, req_value, req_err, input req_ready);
  modport slave  (input req_valid, req_op, req_value, req_err, output req_ready);
endinterface

// File: rtl/fnd_display_sequencer.sv
// Chooses the 32-bit display code for the FND driver: HAPPY banner, operator word hold,
// then the result or an error word. Define FND_ERR_BLINK_EN to make the error word blink.
module fnd_display_sequencer #(
  parameter int TICK_DIV   = 50000,
  parameter int OP_HOLD    = 1000,
  parameter int BLINK_HALF = 250
) (
  input  logic                     clk,
  input  logic                     rst,
  fnd_display_sequencer_if.slave   req,
  output logic [31:0]              fnd_serial,
  output logic                     busy
);

  localparam logic [31:0] W_NULL     = 32'h00CC_0000;
  localparam logic [31:0] W_ERR      = 32'h00EE_0000;
  localparam logic [31:0] W_PLUS     = 32'h0010_0000;
  localparam logic [31:0] W_MINUS    = 32'h0020_0000;
  localparam logic [31:0] W_MULTIPLE = 32'h0030_0000;
  localparam logic [31:0] W_DIVID    = 32'h0040_0000;
  localparam logic [31:0] W_MODULO   = 32'h0050_0000;
  localparam logic [31:0] W_HAPPY    = 32'h00A0_0000;

  localparam int PW       = $clog2(TICK_DIV);
  localparam int HOLD_MAX = (OP_HOLD > BLINK_HALF) ? OP_HOLD : BLINK_HALF;
  localparam int TW       = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_OP, S_VAL, S_ERR} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0]   value_q, value_d;
  logic [31:0]   fnd_q, fnd_d;
  logic [2:0]    op_q, op_d;
  logic          bad_q, bad_d;
  logic          ready_q, ready_d;
`ifdef FND_ERR_BLINK_EN
  logic          blink_q, blink_d;
`endif

  logic               tick;
  logic               accept;
  logic               in_range;
  logic signed [31:0] req_sval;

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign accept   = req.req_valid & ready_q;
  assign req_sval = $signed(req.req_value);
  // Word codes all exceed 999999, so anything inside this window is safe to show as a number.
  assign in_range = (req_sval >= -32'sd99999) && (req_sval <= 32'sd999999);

  function automatic logic [31:0] op_word(input logic [2:0] op);
    case (op)
      3'd1:    op_word = W_PLUS;
      3'd2:    op_word = W_MINUS;
      3'd3:    op_word = W_MULTIPLE;
      3'd4:    op_word = W_DIVID;
      3'd5:    op_word = W_MODULO;
      default: op_word = W_ERR;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + PW'(1);
    tcnt_d  = tcnt_q;
    value_d = value_q;
    op_d    = op_q;
    bad_d   = bad_q;
`ifdef FND_ERR_BLINK_EN
    blink_d = blink_q;
`endif

    case (state_q)
      S_OP: begin
        if (tick) begin
          if (tcnt_q == TW'(OP_HOLD - 1)) state_d = bad_q ? S_ERR : S_VAL;
          else                            tcnt_d  = tcnt_q + TW'(1);
        end
      end
`ifdef FND_ERR_BLINK_EN
      S_ERR: begin
        if (tick) begin
          if (tcnt_q == TW'(BLINK_HALF - 1)) begin
            blink_d = ~blink_q;
            tcnt_d  = '0;
          end else begin
            tcnt_d  = tcnt_q + TW'(1);
          end
        end
      end
`endif
      default: ;
    endcase

    // The error/value decision is fixed here even when the operator word is shown first.
    if (accept) begin
      value_d = req.req_value;
      op_d    = req.req_op;
      bad_d   = req.req_err | ~in_range;
      if (req.req_op >= 3'd6)      state_d = S_ERR;
      else if (req.req_op == 3'd0) state_d = bad_d ? S_ERR : S_VAL;
      else                         state_d = S_OP;
    end

    if (accept || (state_d != state_q)) begin
      presc_d = '0;
      tcnt_d  = '0;
`ifdef FND_ERR_BLINK_EN
      blink_d = 1'b0;
`endif
    end

    ready_d = (state_d != S_OP);

    fnd_d = W_HAPPY;
    case (state_d)
      S_IDLE: fnd_d = W_HAPPY;
      S_OP:   fnd_d = op_word(op_d);
      S_VAL:  fnd_d = value_d;
`ifdef FND_ERR_BLINK_EN
      S_ERR:  fnd_d = blink_d ? W_NULL : W_ERR;
`else
      S_ERR:  fnd_d = W_ERR;
`endif
      default: fnd_d = W_HAPPY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      value_q <= '0;
      op_q    <= '0;
      bad_q   <= 1'b0;
      ready_q <= 1'b0;
      fnd_q   <= W_HAPPY;
`ifdef FND_ERR_BLINK_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      value_q <= value_d;
      op_q    <= op_d;
      bad_q   <= bad_d;
      ready_q <= ready_d;
      fnd_q   <= fnd_d;
`ifdef FND_ERR_BLINK_EN
      blink_q <= blink_d;
`endif
    end
  end

  assign req.req_ready = ready_q;
  assign fnd_serial    = fnd_q;
  assign busy          = (state_q == S_OP);

endmodule

// File: tb/tb_fnd_display_sequencer.sv
// Directed plus randomized bench for fnd_display_sequencer; expected display derived from
// elapsed time since each accept/state entry.
module tb_fnd_display_sequencer;

  localparam int TD = 4;
  localparam int OH = 3;
  localparam int BH = 2;

  localparam logic [31:0] W_NULL  = 32'h00CC_0000;
  localparam logic [31:0] W_ERR   = 32'h00EE_0000;
  localparam logic [31:0] W_HAPPY = 32'h00A0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fnd_serial;
  logic        busy;

  fnd_display_sequencer_if req_if();

  fnd_display_sequencer #(.TICK_DIV(TD), .OP_HOLD(OH), .BLINK_HALF(BH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req_if),
    .fnd_serial (fnd_serial),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef enum {M_IDLE, M_OP, M_VAL, M_ERR} mkind_e;
  mkind_e      m_kind  = M_IDLE;
  int          m_since = 0;
  logic [31:0] m_word  = '0;
  logic [31:0] m_value = '0;
  bit          m_bad   = 1'b0;
  bit          m_rdy   = 1'b0;
  bit          last_acc = 1'b0;

  function automatic logic [31:0] word_of(input logic [2:0] op);
    if (op >= 3'd1 && op <= 3'd5) return {8'h00, 1'b0, op, 20'h0_0000};
    return W_ERR;
  endfunction

  function automatic bit displayable(input logic [31:0] v);
    int sv;
    sv = v;
    return (sv >= -99999) && (sv <= 999999);
  endfunction

  function automatic logic [31:0] exp_fnd();
    case (m_kind)
      M_IDLE: return W_HAPPY;
      M_OP:   return m_word;
      M_VAL:  return m_value;
`ifdef FND_ERR_BLINK_EN
      default: return (((m_since / (BH * TD)) % 2) == 1) ? W_NULL : W_ERR;
`else
      default: return W_ERR;
`endif
    endcase
  endfunction

  task automatic model_accept(input logic [2:0] op, input logic [31:0] v, input logic e);
    m_word  = word_of(op);
    m_value = v;
    m_bad   = e || !displayable(v);
    if (op >= 3'd6)      m_kind = M_ERR;
    else if (op == 3'd0) m_kind = m_bad ? M_ERR : M_VAL;
    else                 m_kind = M_OP;
    m_since = 0;
  endtask

  task automatic model_step();
    m_since++;
    if (m_kind == M_OP && m_since == OH * TD) begin
      m_kind  = m_bad ? M_ERR : M_VAL;
      m_since = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: decide acceptance from pre-edge state, advance model, sample #1 after the edge.
  task automatic cyc(input string tag);
    bit          acc;
    logic [2:0]  op;
    logic [31:0] v;
    logic        e;
    acc = rst && req_if.req_valid && m_rdy;
    op  = req_if.req_op;
    v   = req_if.req_value;
    e   = req_if.req_err;
    @(posedge clk);
    #1;
    if (!rst) begin
      m_kind  = M_IDLE;
      m_since = 0;
      m_rdy   = 1'b0;
    end else begin
      if (acc) model_accept(op, v, e);
      else     model_step();
      m_rdy = (m_kind != M_OP);
    end
    last_acc = acc;
    check({tag, "_fnd"},   fnd_serial,              exp_fnd());
    check({tag, "_busy"},  {31'b0, busy},           {31'b0, (m_kind == M_OP)});
    check({tag, "_ready"}, {31'b0, req_if.req_ready}, {31'b0, m_rdy});
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) cyc(tag);
  endtask

  // Holds req_valid until the model sees it accepted, bounded so a stuck DUT still ends.
  task automatic send(input logic [2:0] op, input logic [31:0] v, input logic e, input string tag);
    int guard;
    req_if.req_op    = op;
    req_if.req_value = v;
    req_if.req_err   = e;
    req_if.req_valid = 1'b1;
    guard = 0;
    do begin
      cyc(tag);
      guard++;
    end while (!last_acc && guard < 100);
    req_if.req_valid = 1'b0;
    req_if.req_value = $urandom;
    req_if.req_op    = 3'($urandom);
    if (!last_acc) check({tag, "_accept_timeout"}, {31'b0, last_acc}, 32'd1);
  endtask

  function automatic logic [31:0] rand_value();
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return $urandom_range(0, 999999);
      2:       return 32'(-int'($urandom_range(0, 99999)));
      3:       return 32'(999999 + int'($urandom_range(0, 1)));
      4:       return 32'(-99999 - int'($urandom_range(0, 1)));
      default: return $urandom_range(0, 9);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_op    = '0;
    req_if.req_value = '0;
    req_if.req_err   = 1'b0;

    // Reset and banner
    rst = 1'b0;
    idle(3, "reset");
    rst = 1'b1;
    idle(3, "release");

    // Operator hold then value
    send(3'd1, 32'd42, 1'b0, "plus42");
    idle(14, "plus42_hold");

    // Direct numbers and range boundaries
    send(3'd0, 32'hFFFF_FFFB, 1'b0, "neg5");
    idle(3, "neg5_show");
    send(3'd0, 32'(-100000), 1'b0, "neg100000");
    idle(3, "neg100000_err");
    send(3'd0, 32'd999999, 1'b0, "max_ok");
    idle(2, "max_ok_show");
    send(3'd0, 32'd1000000, 1'b0, "max_bad");
    idle(2, "max_bad_show");
    send(3'd0, 32'(-99999), 1'b0, "min_ok");
    idle(2, "min_ok_show");

    // Divide error: DIVID hold, ERR/NULL blink, preempt in the NULL half
    send(3'd4, 32'd9, 1'b1, "divid_err");
    idle(11 + 8 + 4, "divid_blink");
    send(3'd0, 32'd3, 1'b0, "preempt");
    idle(3, "preempt_show");

    // Request held through OP is not latched until ready
    send(3'd2, 32'd11, 1'b0, "minus");
    send(3'd0, 32'd7, 1'b0, "held7");
    idle(3, "held7_show");
    send(3'd6, 32'd5, 1'b0, "illegal6");
    idle(3, "illegal6_show");

    // Reset in the middle of OP, then a full sequence
    send(3'd3, 32'd8, 1'b0, "mult");
    idle(4, "mult_hold");
    rst = 1'b0;
    req_if.req_valid = 1'b1;
    cyc("midreset");
    rst = 1'b1;
    send(3'd5, 32'd2, 1'b0, "after_reset");
    idle(14, "after_reset_hold");

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      idle($urandom_range(0, 3), "rnd_gap");
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b0;
        cyc("rnd_reset");
        rst = 1'b1;
      end
      send(3'($urandom_range(0, 7)), rand_value(), ($urandom_range(0, 3) == 0), "rnd_req");
      idle($urandom_range(0, 30), "rnd_run");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
